// File: rtl/serial_receiver.sv
// -----------------------------------------------------------------------------
// serial_receiver
//   8N1 UART-style receiver, LSB first, oversampled at 4 clocks per bit.
//   The line is synchronised through two flops, then a single FSM walks
//   START, BIT0..BIT7 and STOP, sampling each bit at phase 1 of its 4-clock
//   window. A low stop bit reports a framing error and parks the FSM in
//   BREAK until the line returns high, so a stuck-low line yields one error.
//
// Ports
//   clk_x4   in   1  clock, 4x the bit rate
//   rst      in   1  synchronous active-high reset
//   i_rx     in   1  asynchronous serial line, idle high
//   o_data   out  8  last correctly framed byte, held until the next good frame
//   o_valid  out  1  one-cycle pulse, o_data updated in the same cycle
//   o_error  out  1  one-cycle pulse on a framing error
//   o_busy   out  1  high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module serial_receiver (
  input  logic       clk_x4,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_error,
  output logic       o_busy
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    START = 4'd1,
    BIT0  = 4'd2,
    BIT1  = 4'd3,
    BIT2  = 4'd4,
    BIT3  = 4'd5,
    BIT4  = 4'd6,
    BIT5  = 4'd7,
    BIT6  = 4'd8,
    BIT7  = 4'd9,
    STOP  = 4'd10,
    BREAK = 4'd11
  } state_e;

  logic       sync1_q;
  logic       sync2_q;
  logic       w_rx;
  state_e     state_q;
  logic [1:0] phase_q;
  logic [7:0] shift_q;
  logic [7:0] data_q;
  logic       valid_q;
  logic       error_q;

  // Shift-register position for the bit state currently being received.
  function automatic logic [2:0] bit_index(input state_e s);
    case (s)
      BIT0:    bit_index = 3'd0;
      BIT1:    bit_index = 3'd1;
      BIT2:    bit_index = 3'd2;
      BIT3:    bit_index = 3'd3;
      BIT4:    bit_index = 3'd4;
      BIT5:    bit_index = 3'd5;
      BIT6:    bit_index = 3'd6;
      BIT7:    bit_index = 3'd7;
      default: bit_index = 3'd0;
    endcase
  endfunction

  // Successor of a bit state; BIT7 hands over to STOP.
  function automatic state_e next_bit(input state_e s);
    case (s)
      BIT0:    next_bit = BIT1;
      BIT1:    next_bit = BIT2;
      BIT2:    next_bit = BIT3;
      BIT3:    next_bit = BIT4;
      BIT4:    next_bit = BIT5;
      BIT5:    next_bit = BIT6;
      BIT6:    next_bit = BIT7;
      BIT7:    next_bit = STOP;
      default: next_bit = IDLE;
    endcase
  endfunction

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk_x4) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
    end
  end

  assign w_rx = sync2_q;

  // Receive FSM with phase counter, shift register and registered pulses.
  always_ff @(posedge clk_x4) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= 2'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          phase_q <= 2'd0;
          if (!w_rx) begin
            state_q <= START;
          end else begin
            state_q <= IDLE;
          end
        end
        START: begin
          // A start bit already high again at its mid-point is a glitch.
          if (phase_q == 2'd1 && w_rx) begin
            state_q <= IDLE;
            phase_q <= 2'd0;
          end else if (phase_q == 2'd3) begin
            state_q <= BIT0;
            phase_q <= 2'd0;
          end else begin
            phase_q <= phase_q + 2'd1;
          end
        end
        BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7: begin
          phase_q <= phase_q + 2'd1;
          if (phase_q == 2'd1) begin
            shift_q[bit_index(state_q)] <= w_rx;
          end
          if (phase_q == 2'd3) begin
            state_q <= next_bit(state_q);
          end
        end
        STOP: begin
          // Decide at the stop-bit sample so a back-to-back start is not missed.
          if (phase_q == 2'd1) begin
            phase_q <= 2'd0;
            if (w_rx) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              error_q <= 1'b1;
              state_q <= BREAK;
            end
          end else begin
            phase_q <= phase_q + 2'd1;
          end
        end
        BREAK: begin
          phase_q <= 2'd0;
          if (w_rx) begin
            state_q <= IDLE;
          end else begin
            state_q <= BREAK;
          end
        end
        default: begin
          state_q <= IDLE;
          phase_q <= 2'd0;
        end
      endcase
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_error = error_q;
  assign o_busy  = (state_q != IDLE);

endmodule
